// File: rtl/mem_responder.sv
// Word-addressed RAM responder: strobe requests are latched on acceptance and
// complete after LATENCY edges with a one-cycle Done pulse.
module mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Done,
  output logic                  Busy
);

  // state | meaning
  // IDLE  | no request in flight, strobes sampled
  // WAIT  | request latched, counting down to completion
  // ACK   | Done high for this cycle; a held strobe is accepted here

  localparam int CW    = $clog2(LATENCY) + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    op_write;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    complete;

  assign complete = (state == S_WAIT) && (cnt == '0);
  assign Busy     = (state != S_IDLE);

  // The array has no reset; Clear on the completing edge suppresses the write.
  always_ff @(posedge Clock) begin
    if (!Clear && complete && op_write) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state   <= S_IDLE;
      Done    <= 1'b0;
      DataOut <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        // Leaving ACK is the re-entry into IDLE, so a held strobe starts the
        // next transaction on that same edge (back-to-back every LATENCY+1).
        S_IDLE, S_ACK: begin
          Done <= 1'b0;
          if (Write || Read) begin
            addr_q   <= Address;
            op_write <= Write;
            if (Write) begin
              data_q <= DataIn;
            end
            cnt   <= CW'(LATENCY - 1);
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!op_write) begin
              DataOut <= mem[addr_q];
            end
            Done  <= 1'b1;
            state <= S_ACK;
          end
        end
        default: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: accepted requests queue their expected
// completion (edge and data); a negedge monitor checks Done, Busy and DataOut.
module tb_mem_responder;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 2 ** AW;

  logic          Clock = 1'b0;
  logic          Clear, Read, Write;
  logic [AW-1:0] Address;
  logic [DW-1:0] DataIn, DataOut;
  logic          Done, Busy;

  logic          clr1, rd1, wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] din1, dout1;
  logic          done1, busy1;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .Clock(Clock), .Clear(Clear), .Address(Address), .DataIn(DataIn),
    .Read(Read), .Write(Write), .DataOut(DataOut), .Done(Done), .Busy(Busy)
  );

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) u_lat1 (
    .Clock(Clock), .Clear(clr1), .Address(addr1), .DataIn(din1),
    .Read(rd1), .Write(wr1), .DataOut(dout1), .Done(done1), .Busy(busy1)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } txn_t;

  txn_t          sbq[$];
  txn_t          acc_t;
  txn_t          mon_t;
  logic [DW-1:0] mem_m [int];
  int            keys[$];
  logic [DW-1:0] last_read = '0;
  int            neg_cnt = 0;
  int            free_at = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            prev_done = 1'b0;
  bit            exp_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request is taken whenever the responder is free (idle, or on
  // its ACK edge); it completes LAT edges later and Done shows the cycle after.
  always @(posedge Clock) begin
    if (Clear) begin
      sbq.delete();
      last_read = '0;
      free_at   = neg_cnt;
    end else if ((Read || Write) && neg_cnt >= free_at) begin
      acc_t.wr   = Write;
      acc_t.addr = Address;
      if (Write) acc_t.data = DataIn;
      else acc_t.data = mem_m.exists(int'(Address)) ? mem_m[int'(Address)] : 'x;
      acc_t.due = neg_cnt + LAT + 1;
      sbq.push_back(acc_t);
      free_at = neg_cnt + LAT + 1;
    end
  end

  always @(negedge Clock) begin
    neg_cnt++;
    exp_done = (sbq.size() > 0) && (sbq[0].due == neg_cnt);
    check("done", 64'(Done), 64'(exp_done));
    check("busy", 64'(Busy), 64'(neg_cnt <= free_at));
    check("done_not_consecutive", 64'(Done && prev_done), 64'd0);
    prev_done = Done;
    if (exp_done) begin
      mon_t = sbq.pop_front();
      if (mon_t.wr) begin
        check("dataout_after_write", 64'(DataOut), 64'(last_read));
        if (!mem_m.exists(int'(mon_t.addr))) keys.push_back(int'(mon_t.addr));
        mem_m[int'(mon_t.addr)] = mon_t.data;
      end else begin
        check("dataout_read", 64'(DataOut), 64'(mon_t.data));
        last_read = mon_t.data;
      end
    end
  end

  // Called and returns just after a falling edge.
  task automatic issue(input bit rd, input bit wr, input int addr, input logic [DW-1:0] d);
    int guard = 0;
    while (neg_cnt < free_at) begin
      @(negedge Clock);
      #1;
      guard++;
      if (guard > 40) begin
        check("issue_wait_timeout", 64'd1, 64'd0);
        break;
      end
    end
    Read    = rd;
    Write   = wr;
    Address = AW'(addr);
    DataIn  = d;
    @(posedge Clock);
    #1;
    Read    = 1'b0;
    Write   = 1'b0;
    Address = AW'(addr + 1);
    DataIn  = ~d;
    @(negedge Clock);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq.size() != 0 || neg_cnt < free_at) && guard < 30) begin
      @(negedge Clock);
      #1;
      guard++;
    end
    if (guard >= 30) check("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Clear = 1'b1; Read = 1'b0; Write = 1'b0; Address = '0; DataIn = '0;
    clr1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    check("reset_dataout", 64'(DataOut), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    Clear = 1'b0;
    clr1  = 1'b0;

    // memory survives Clear
    issue(0, 1, 5, 32'hDEADBEEF);
    drain();
    Clear = 1'b1;
    @(posedge Clock);
    #1;
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    check("clear_dataout", 64'(DataOut), 64'd0);
    issue(1, 0, 5, '0);
    drain();

    issue(0, 1, 'h010, 32'h12345678);
    issue(1, 0, 'h010, '0);
    issue(1, 1, 'h1FF, 32'hA5A5A5A5);
    issue(1, 0, 'h1FF, '0);
    issue(0, 1, 3, 32'h33);
    issue(0, 1, 4, 32'h44);
    issue(1, 0, 3, '0);
    issue(0, 1, 2, 32'h2222_0002);
    drain();

    // abort: Clear lands on the completing edge of a write
    issue(0, 1, 7, 32'h7);
    drain();
    Write = 1'b1; Address = 7; DataIn = '1;
    @(posedge Clock);
    #1;
    Write = 1'b0;
    repeat (LAT - 1) @(posedge Clock);
    #1;
    Clear = 1'b1;
    @(posedge Clock);
    #1;
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_dataout", 64'(DataOut), 64'd0);
    issue(1, 0, 7, '0);
    drain();

    // back-to-back: held read strobe
    Read = 1'b1; Address = 2;
    repeat (7) @(posedge Clock);
    #1;
    Read = 1'b0;
    @(negedge Clock);
    #1;
    drain();

    for (int i = 0; i < 150; i++) begin
      int a;
      bit rd, wr;
      logic [DW-1:0] d;
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clock);
        #1;
      end
      d = $urandom;
      case ($urandom_range(0, 3))
        0: a = 0;
        1: a = DEPTH - 1;
        default: a = $urandom_range(0, DEPTH - 1);
      endcase
      if (keys.size() == 0 || $urandom_range(0, 2) == 0) begin
        wr = 1'b1;
        rd = 1'($urandom_range(0, 1));
      end else begin
        wr = 1'b0;
        rd = 1'b1;
        a  = keys[$urandom_range(0, keys.size() - 1)];
      end
      issue(rd, wr, a, d);
    end
    drain();

    // LATENCY=1 instance: write, then a held read strobe
    addr1 = 9; din1 = 32'hCAFE0009; wr1 = 1'b1;
    @(posedge Clock);
    #1;
    wr1 = 1'b0; rd1 = 1'b1; din1 = 32'h0BAD0BAD;
    @(negedge Clock);
    check("l1_done_accept", 64'(done1), 64'd0);
    check("l1_busy_accept", 64'(busy1), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clock);
      #1;
      if (i == 6) rd1 = 1'b0;
      @(negedge Clock);
      check("l1_done", 64'(done1), 64'(i % 2 == 1));
      if (i % 2 == 1) check("l1_dataout", 64'(dout1), (i == 1) ? 64'd0 : 64'hCAFE0009);
      check("l1_busy", 64'(busy1), 64'(i <= 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
